// File: rtl/serial_addsub_ctrl.sv
// Multi-cycle adder/subtractor: one DIGIT-bit ripple slice walks the operands LSB chunk first.
// Ports: clk, reset (async high), start_* request handshake, a/b/sub operands, result_* handshake, flags, busy.
module serial_addsub_ctrl #(
  parameter int WIDTH = 32,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             result_valid,
  input  logic             result_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow,
  output logic             busy
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  if ((DIGIT < 1) || (WIDTH % DIGIT != 0)) begin : g_bad_cfg
    $error("serial_addsub_ctrl: WIDTH must be a multiple of DIGIT");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_result;
  logic             r_carry;
  logic             r_cout;
  logic             r_ovf;

  logic             w_last;
  logic             w_load;
  logic             w_step;
  logic [DIGIT-1:0] w_sum;
  logic             w_c;
  logic             w_c_msb;
  logic             w_c_out;
  logic [WIDTH-1:0] w_res_nxt;

  assign w_last = (r_cnt == CW'(N - 1));
  assign w_load = (r_state == S_IDLE) && start_valid;
  assign w_step = (r_state == S_BUSY);

  // Ripple slice over the low chunk; the operands shift right each step
  always_comb begin
    w_sum   = '0;
    w_c     = r_carry;
    w_c_msb = 1'b0;
    for (int i = 0; i < DIGIT; i++) begin
      if (i == DIGIT - 1) w_c_msb = w_c;
      w_sum[i] = r_a[i] ^ r_b[i] ^ w_c;
      w_c = (r_a[i] & r_b[i]) | (r_a[i] & w_c) | (r_b[i] & w_c);
    end
    w_c_out = w_c;
  end

  // New sum chunk enters at the top; after N steps the word is aligned
  if (N == 1) begin : g_one
    assign w_res_nxt = w_sum;
  end else begin : g_many
    assign w_res_nxt = {w_sum, r_result[WIDTH-1:DIGIT]};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next       = r_state;
    start_ready  = 1'b0;
    result_valid = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        start_ready = ~reset;
        if (start_valid) w_next = S_BUSY;
      end
      S_BUSY: begin
        if (w_last) w_next = S_DONE;
      end
      S_DONE: begin
        result_valid = 1'b1;
        if (result_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt    <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_result <= '0;
      r_carry  <= 1'b0;
      r_cout   <= 1'b0;
      r_ovf    <= 1'b0;
    end else if (w_load) begin
      // Subtract as a + ~b + 1
      r_a     <= a;
      r_b     <= sub ? ~b : b;
      r_carry <= sub;
      r_cnt   <= '0;
    end else if (w_step) begin
      r_a      <= r_a >> DIGIT;
      r_b      <= r_b >> DIGIT;
      r_carry  <= w_c_out;
      r_result <= w_res_nxt;
      if (w_last) begin
        r_cnt  <= '0;
        r_cout <= w_c_out;
        r_ovf  <= w_c_msb ^ w_c_out;
      end else begin
        r_cnt  <= r_cnt + 1'b1;
      end
    end
  end

  assign result    = r_result;
  assign carry_out = r_cout;
  assign overflow  = r_ovf;
  assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_serial_addsub_ctrl.sv
// Scoreboard bench for serial_addsub_ctrl: three configurations (8/2, 32/4, 8/8).
// Drivers push expected results; one monitor pops on each result handshake.
module tb_serial_addsub_ctrl;

  typedef struct {
    int          tag;
    logic [31:0] res;
    logic        co;
    logic        ov;
    int          acc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  sv, sb, rr;
  logic [2:0]  srdy, rv, co, ov, bsy;
  logic [31:0] av [3];
  logic [31:0] bv [3];
  logic [7:0]  res0, res2;
  logic [31:0] res1;

  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;
  exp_t sbq[$];
  int   seen [3];
  int   first [3];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  serial_addsub_ctrl #(.WIDTH(8), .DIGIT(2)) u0 (
    .clk(clk), .reset(rst),
    .start_valid(sv[0]), .start_ready(srdy[0]),
    .a(av[0][7:0]), .b(bv[0][7:0]), .sub(sb[0]),
    .result_valid(rv[0]), .result_ready(rr[0]),
    .result(res0), .carry_out(co[0]), .overflow(ov[0]),
    .busy(bsy[0])
  );

  serial_addsub_ctrl #(.WIDTH(32), .DIGIT(4)) u1 (
    .clk(clk), .reset(rst),
    .start_valid(sv[1]), .start_ready(srdy[1]),
    .a(av[1]), .b(bv[1]), .sub(sb[1]),
    .result_valid(rv[1]), .result_ready(rr[1]),
    .result(res1), .carry_out(co[1]), .overflow(ov[1]),
    .busy(bsy[1])
  );

  serial_addsub_ctrl #(.WIDTH(8), .DIGIT(8)) u2 (
    .clk(clk), .reset(rst),
    .start_valid(sv[2]), .start_ready(srdy[2]),
    .a(av[2][7:0]), .b(bv[2][7:0]), .sub(sb[2]),
    .result_valid(rv[2]), .result_ready(rr[2]),
    .result(res2), .carry_out(co[2]), .overflow(ov[2]),
    .busy(bsy[2])
  );

  function automatic int nof(input int i);
    case (i)
      0:       return 4;
      1:       return 8;
      default: return 1;
    endcase
  endfunction

  function automatic logic [31:0] getres(input int i);
    case (i)
      0:       return {24'h0, res0};
      1:       return res1;
      default: return {24'h0, res2};
    endcase
  endfunction

  function automatic int cnt_tag(input int i);
    int n = 0;
    foreach (sbq[k]) if (sbq[k].tag == i) n++;
    return n;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, req);
  endtask

  task automatic fail_now(input string nm);
    n_chk++;
    $display("FAIL %s: timeout at cycle %0d", nm, cyc);
  endtask

  // Monitor: handshake checks, output hold and latency
  always @(negedge clk) begin
    int idx;
    exp_t e;
    if (!rst) begin
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("rdy%0d", i), {63'h0, srdy[i]}, {63'h0, ~bsy[i]});
        if (rv[i]) begin
          idx = -1;
          foreach (sbq[k]) if (idx < 0 && sbq[k].tag == i) idx = k;
          if (idx < 0) begin
            n_chk++;
            $display("FAIL unexp%0d: result_valid with nothing expected", i);
          end else begin
            e = sbq[idx];
            chk($sformatf("hold%0d", i), {ov[i], co[i], getres(i)},
                {e.ov, e.co, e.res});
            if (seen[i] == 0) begin
              seen[i]  = 1;
              first[i] = cyc;
              chk($sformatf("lat%0d", i), first[i] - e.acc, nof(i));
            end
            if (rr[i]) begin
              sbq.delete(idx);
              seen[i] = 0;
            end
          end
        end
      end
    end else begin
      for (int i = 0; i < 3; i++) seen[i] = 0;
    end
  end

  task automatic issue(input int i, input logic [31:0] a,
                       input logic [31:0] b, input logic s,
                       input logic [31:0] er, input logic eco,
                       input logic eov, input bit push, input bit keep,
                       output int acc);
    av[i] = a;
    bv[i] = b;
    sb[i] = s;
    sv[i] = 1'b1;
    acc   = -1;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (srdy[i]) begin
        acc = cyc + 1;
        break;
      end
    end
    if (acc < 0) begin
      fail_now($sformatf("accept%0d", i));
      sv[i] = 1'b0;
      return;
    end
    if (push) sbq.push_back('{i, er, eco, eov, acc});
    @(posedge clk);
    #1;
    if (!keep) sv[i] = 1'b0;
  endtask

  task automatic wait_done(input int i);
    bit ok = 0;
    for (int t = 0; t < 400; t++) begin
      @(negedge clk);
      if (!bsy[i] && cnt_tag(i) == 0) begin
        ok = 1;
        break;
      end
    end
    if (!ok) fail_now($sformatf("drain%0d", i));
    @(posedge clk);
    #1;
  endtask

  initial begin
    int a1, a2, ac;
    bit got;
    rst = 1'b1;
    sv  = '0;
    sb  = '0;
    rr  = 3'b111;
    for (int i = 0; i < 3; i++) begin
      av[i] = '0;
      bv[i] = '0;
      seen[i] = 0;
      first[i] = 0;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("rst_u0", {res0, co[0], ov[0], rv[0], bsy[0]}, 0);
    chk("rst_u1", {res1, co[1], ov[1], rv[1], bsy[1]}, 0);
    chk("rst_u2", {res2, co[2], ov[2], rv[2], bsy[2]}, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("rdy_after_rst", {61'h0, srdy}, 3'b111);
    @(posedge clk);
    #1;

    issue(0, 32'h7F, 32'h01, 1'b0, 32'h80, 1'b0, 1'b1, 1, 0, ac);
    wait_done(0);
    issue(0, 32'h00, 32'h01, 1'b1, 32'hFF, 1'b0, 1'b0, 1, 0, ac);
    issue(0, 32'h05, 32'h03, 1'b1, 32'h02, 1'b1, 1'b0, 1, 0, ac);
    wait_done(0);

    // Back-to-back with start_valid held; second operands arrive mid-op
    issue(0, 32'hFF, 32'h01, 1'b0, 32'h00, 1'b1, 1'b0, 1, 1, a1);
    issue(0, 32'h80, 32'h01, 1'b1, 32'h7F, 1'b1, 1'b1, 1, 0, a2);
    chk("b2b_gap", a2 - a1, 6);
    wait_done(0);

    // Backpressure in DONE
    rr[0] = 1'b0;
    issue(0, 32'h3C, 32'h0F, 1'b1, 32'h2D, 1'b1, 1'b0, 1, 0, ac);
    got = 0;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (rv[0]) begin
        got = 1;
        break;
      end
    end
    if (!got) fail_now("bp_valid");
    repeat (4) @(negedge clk);
    @(posedge clk);
    #1;
    rr[0] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_idle", {rv[0], bsy[0]}, 0);
    @(posedge clk);
    #1;

    // Async reset with counter at 2; the aborted op must never emit
    issue(0, 32'hA5, 32'h5A, 1'b0, 32'h0, 1'b0, 1'b0, 0, 0, ac);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst", {res0, co[0], ov[0], rv[0], bsy[0]}, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (8) @(negedge clk);
    @(posedge clk);
    #1;
    issue(0, 32'h12, 32'h34, 1'b0, 32'h46, 1'b0, 1'b0, 1, 0, ac);
    wait_done(0);

    issue(1, 32'h7FFFFFFF, 32'h1, 1'b0, 32'h80000000, 1'b0, 1'b1, 1, 0, ac);
    issue(1, 32'hFFFFFFFF, 32'h1, 1'b0, 32'h00000000, 1'b1, 1'b0, 1, 0, ac);
    issue(1, 32'h12345678, 32'h11111111, 1'b1, 32'h01234567, 1'b1, 1'b0,
          1, 0, ac);
    issue(1, 32'h0, 32'h1, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0, 1, 0, ac);
    issue(1, 32'h80000000, 32'h1, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1, 1, 0, ac);
    issue(1, 32'hDEADBEEF, 32'h01010101, 1'b0, 32'hDFAEBFF0, 1'b0, 1'b0,
          1, 0, ac);
    wait_done(1);

    issue(2, 32'h7F, 32'h01, 1'b0, 32'h80, 1'b0, 1'b1, 1, 0, ac);
    issue(2, 32'hFF, 32'hFF, 1'b0, 32'hFE, 1'b1, 1'b0, 1, 0, ac);
    issue(2, 32'h05, 32'h03, 1'b1, 32'h02, 1'b1, 1'b0, 1, 0, ac);
    issue(2, 32'h00, 32'h01, 1'b1, 32'hFF, 1'b0, 1'b0, 1, 0, ac);
    issue(2, 32'h80, 32'h01, 1'b1, 32'h7F, 1'b1, 1'b1, 1, 0, ac);
    wait_done(2);

    chk("sb_empty", sbq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
